// File: rtl/image_pkg.sv
// Shared types and constants for the 3x3 window generator.
package image_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam int NUM_LB    = 4;
  localparam int PIX_W     = 8;
  localparam int ROW_W     = 3 * PIX_W;
  localparam int WIN_BYTES = 9;
  localparam int WIN_W     = WIN_BYTES * PIX_W;

  // LSB of window element (row, col) inside the 72-bit window.
  function automatic int win_byte_lsb(input int row, input int col);
    return (row * 3 + col) * PIX_W;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels: single write port, three adjacent pixels read
// combinationally starting at rd_ptr (leftmost pixel in the low byte).
module line_buffer
  import image_pkg::*;
#(
  parameter int IMG_W = 512,
  localparam int PTR_W = $clog2(IMG_W)
) (
  input  logic             i_clk,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [ROW_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [IMG_W];

  // Store an accepted pixel; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Three-wide read; rd_ptr never exceeds IMG_W-3 so rd_ptr+2 stays in range.
  always_comb begin
    rd_data = {mem[rd_ptr + PTR_W'(2)], mem[rd_ptr + PTR_W'(1)], mem[rd_ptr]};
  end

endmodule

// File: rtl/image_window_ctrl.sv
// Streaming 3x3 window generator over four rotating line buffers.
//
// Handshake: a pixel is accepted on a rising edge where i_pixel_data_valid
// and o_ready are both high; when o_ready is low the write is dropped with no
// pointer or count change. The output side has no backpressure: every cycle
// with o_pixel_data_valid high carries one new window.
//
// READ_ENABLE = 0 parks the FSM in IDLE so the buffers can be filled to the
// full-gate limit; normal use leaves it at 1.
module image_window_ctrl
  import image_pkg::*;
#(
  parameter int IMG_W       = 512,
  parameter bit READ_ENABLE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic             o_ready,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr
);

  localparam int PTR_W = $clog2(IMG_W);
  localparam int PC_W  = $clog2(4 * IMG_W + 1);
  localparam logic [PTR_W-1:0] LAST_WR = PTR_W'(IMG_W - 1);
  localparam logic [PTR_W-1:0] LAST_X  = PTR_W'(IMG_W - 3);
  localparam logic [PC_W-1:0]  FULL    = PC_W'(4 * IMG_W);
  localparam logic [PC_W-1:0]  START   = PC_W'(3 * IMG_W);
  localparam logic [PC_W-1:0]  LINE    = PC_W'(IMG_W);

  state_t           state, state_next;
  logic [1:0]       wr_sel, rd_sel, rd_sel_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [PC_W-1:0]  pix_count, pix_count_next;
  logic             accept, issue, retire;
  logic [ROW_W-1:0] lb_rd [NUM_LB];
  logic [WIN_W-1:0] window;

  assign accept = i_pixel_data_valid && o_ready;

  for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
    line_buffer #(.IMG_W(IMG_W)) u_lb (
      .i_clk  (i_clk),
      .wr_en  (accept && (wr_sel == 2'(i))),
      .wr_data(i_pixel_data),
      .wr_ptr (wr_ptr),
      .rd_ptr (rd_ptr),
      .rd_data(lb_rd[i])
    );
  end

  // Occupancy: +1 per accepted pixel, -IMG_W when a line is retired.
  always_comb begin
    pix_count_next = pix_count + PC_W'(accept) - (retire ? LINE : '0);
  end

  // Write pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_sel    <= '0;
      wr_ptr    <= '0;
      pix_count <= '0;
      o_ready   <= 1'b1;
    end else begin
      if (accept) begin
        if (wr_ptr == LAST_WR) begin
          wr_ptr <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      pix_count <= pix_count_next;
      o_ready   <= (pix_count_next < FULL);
    end
  end

  // Row mux: rd_sel is the top row, the next two buffers (mod 4) follow.
  always_comb begin
    window = {lb_rd[rd_sel + 2'd2], lb_rd[rd_sel + 2'd1], lb_rd[rd_sel]};
  end

  // Pass control: start once three lines are held, issue one column per cycle.
  always_comb begin
    state_next  = state;
    rd_ptr_next = rd_ptr;
    rd_sel_next = rd_sel;
    issue       = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        if (READ_ENABLE && (pix_count >= START)) begin
          state_next  = READ;
          rd_ptr_next = '0;
        end
      end
      READ: begin
        issue = 1'b1;
        if (rd_ptr == LAST_X) begin
          retire      = 1'b1;
          state_next  = IDLE;
          rd_sel_next = rd_sel + 2'd1;
          rd_ptr_next = '0;
        end else begin
          rd_ptr_next = rd_ptr + PTR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and read pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      rd_sel <= '0;
    end else begin
      state  <= state_next;
      rd_ptr <= rd_ptr_next;
      rd_sel <= rd_sel_next;
    end
  end

  // Registered window output; intr lands on the same cycle as the last window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      if (issue) begin
        o_pixel_data <= window;
      end
      o_pixel_data_valid <= issue;
      o_intr             <= retire;
    end
  end

endmodule
